dma_ctrl: RTL

DMA_CTRL -- requirements
Module: dma_ctrl

---
 rtl/dma_ctrl_if.sv | 28 ++
 rtl/dma_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/dma_ctrl_if.sv
// Bus bundle for dma_ctrl: start/config, memory read port, downstream word port, irq.
// slave = the controller, master = whatever drives it.
interface dma_ctrl_if;
    logic        start;
    logic [31:0] src_base;
    logic [15:0] len;
    logic        cpu_mem_req;
    logic        dma_mem_rd;
    logic [31:0] dma_addr;
    logic [31:0] mem_rdata;
    logic        en;
    logic [31:0] memDataOut;
    logic [31:0] memAddr;
    logic        nextTransaction;
    logic        busy;
    logic        done;
    logic        irq;
    logic        irq_ack;

    modport master (
        output start, src_base, len, cpu_mem_req, mem_rdata, nextTransaction, irq_ack,
        input  dma_mem_rd, dma_addr, en, memDataOut, memAddr, busy, done, irq
    );
    modport slave (
        input  start, src_base, len, cpu_mem_req, mem_rdata, nextTransaction, irq_ack,
        output dma_mem_rd, dma_addr, en, memDataOut, memAddr, busy, done, irq
    );
endinterface

// File: rtl/dma_ctrl.sv
// Word-read DMA: streams len words from src_base through a 2-entry FIFO, yielding to the CPU.
// Optional sticky completion interrupt when DMA_CTRL_IRQ_EN is defined.
module dma_ctrl (
    input  logic      clk,
    input  logic      rst_n,   // active-high despite the name
    dma_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } fifo_ent_t;

    state_t      state, state_nxt;
    logic [31:0] rd_ptr, fl_addr;
    logic [15:0] rd_cnt, out_cnt;
    logic        fl_vld;
    fifo_ent_t   fifo [2];
    logic        wr_sel, rd_sel;
    logic [1:0]  fifo_cnt;
    logic        issue, push, pop, start_ok;

    assign start_ok = (state == IDLE) && bus.start;
    assign push     = fl_vld;
    assign pop      = bus.en && bus.nextTransaction;
    // In-flight read counts against FIFO space so its data always has a slot.
    assign issue    = (state == READ) && !bus.cpu_mem_req && (rd_cnt != 16'd0) &&
                      ((fifo_cnt + {1'b0, fl_vld}) < 2'd2);

    assign bus.dma_mem_rd = issue;
    assign bus.dma_addr   = rd_ptr;
    assign bus.en         = (fifo_cnt != 2'd0);
    assign bus.memDataOut = fifo[rd_sel].data;
    assign bus.memAddr    = fifo[rd_sel].addr;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bus.busy  = 1'b1;
        bus.done  = 1'b0;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) state_nxt = (bus.len != 16'd0) ? READ : DONE;
            end
            READ:  if (rd_cnt == 16'd0) state_nxt = DRAIN;
            DRAIN: if (out_cnt == 16'd0) state_nxt = DONE;
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rd_ptr  <= '0;
            rd_cnt  <= '0;
            out_cnt <= '0;
            fl_vld  <= 1'b0;
            fl_addr <= '0;
        end else begin
            fl_vld <= issue;
            if (issue) fl_addr <= rd_ptr;
            if (start_ok) begin
                rd_ptr  <= bus.src_base;
                rd_cnt  <= bus.len;
                out_cnt <= bus.len;
            end else begin
                if (issue) begin
                    rd_ptr <= rd_ptr + 32'd4;
                    rd_cnt <= rd_cnt - 16'd1;
                end
                if (pop) out_cnt <= out_cnt - 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            fifo[0]  <= '0;
            fifo[1]  <= '0;
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo[wr_sel] <= '{addr: fl_addr, data: bus.mem_rdata};
                wr_sel       <= ~wr_sel;
            end
            if (pop) rd_sel <= ~rd_sel;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

`ifdef DMA_CTRL_IRQ_EN
    logic irq_q;
    // A new completion takes priority over an acknowledge in the same cycle.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)            irq_q <= 1'b0;
        else if (bus.done)    irq_q <= 1'b1;
        else if (bus.irq_ack) irq_q <= 1'b0;
    end
    assign bus.irq = irq_q;
`else
    logic unused_irq_ack;
    assign unused_irq_ack = bus.irq_ack;
    assign bus.irq        = 1'b0;
`endif
endmodule
